// File: rtl/dmem_port_arbiter.sv
// Purpose : shares one single-port data memory between the CPU load/store port (m0) and a loader/debug port (m1).
// Latency : request sampled at edge E -> strobes for MEM_LAT cycles -> one-cycle ack in cycle E+MEM_LAT+1.
// Backpressure: req/ack handshake; a requester holds req and fields until ack, and the loser waits in place.
//
// Ports:
//   clk_i, rst_i           clock (rising edge), asynchronous active-low reset
//   mN_req_i/we_i          request and write-enable for port N (0 = CPU, 1 = loader)
//   mN_addr_i/wdata_i      byte address and write data, sampled only when the port is granted
//   mN_ack_o               one-cycle completion pulse
//   mN_rdata_o             last read data for port N, held until that port's next read completes
//   mem_addr_o/wdata_o     registered address/data towards Data_Memory
//   mem_read_o/write_o     Data_Memory strobes (read held for the whole access, write for the first cycle)
//   mem_rdata_i            Data_Memory combinational read data
//   busy_o, owner_o        access in progress; port of the current/last grant
// Build option: DMEM_ARB_FIXED_PRIO_EN -> port 0 always wins a tie (default: round-robin).
module dmem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              owner_o
);

  // MEM_LAT is at most 4, so the remaining-cycle counter never exceeds 3.
  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic              owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic              ack0_q;
  logic              ack1_q;
  logic              busy_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic              ptr_q;      // port granted last; the other port wins the next tie
`endif

  logic              any_req_d;
  logic              grant_d;
  logic              sel_we_d;
  logic [ADDR_W-1:0] sel_addr_d;
  logic [DATA_W-1:0] sel_wdata_d;

  // Winner selection; only consumed in IDLE, so requests arriving mid-access just wait.
  always_comb begin
    any_req_d = m0_req_i | m1_req_i;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    grant_d = ~m0_req_i;
`else
    if (m0_req_i && m1_req_i) begin
      grant_d = ~ptr_q;
    end else begin
      grant_d = m1_req_i;
    end
`endif
    sel_we_d    = grant_d ? m1_we_i    : m0_we_i;
    sel_addr_d  = grant_d ? m1_addr_i  : m0_addr_i;
    sel_wdata_d = grant_d ? m1_wdata_i : m0_wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      owner_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      ptr_q       <= 1'b1;
`endif
    end else begin
      // Acks are single-cycle pulses unless re-asserted below.
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req_d) begin
            state_q     <= ACCESS;
            owner_q     <= grant_d;
            we_q        <= sel_we_d;
            addr_q      <= sel_addr_d;
            wdata_q     <= sel_wdata_d;
            cnt_q       <= CNT_W'(MEM_LAT - 1);
            mem_read_q  <= ~sel_we_d;
            mem_write_q <= sel_we_d;
            busy_q      <= 1'b1;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            ptr_q       <= grant_d;
`endif
          end
        end
        ACCESS: begin
          // Write strobe is a single pulse in the first access cycle.
          mem_write_q <= 1'b0;
          if (cnt_q == '0) begin
            state_q    <= RESP;
            mem_read_q <= 1'b0;
            if (!we_q) begin
              if (owner_q) begin
                rdata1_q <= mem_rdata_i;
              end else begin
                rdata0_q <= mem_rdata_i;
              end
            end
            if (owner_q) begin
              ack1_q <= 1'b1;
            end else begin
              ack0_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          // No re-arbitration here: a held request is seen again from IDLE.
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m0_ack_o    = ack0_q;
  assign m1_ack_o    = ack1_q;
  assign m0_rdata_o  = rdata0_q;
  assign m1_rdata_o  = rdata1_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_read_o  = mem_read_q;
  assign mem_write_o = mem_write_q;
  assign busy_o      = busy_q;
  assign owner_o     = owner_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Purpose : self-checking bench for dmem_port_arbiter (MEM_LAT=2 main instance, MEM_LAT=1/4 latency probes).
// Latency : n/a (bench).
// Backpressure: requesters hold req until ack, as a real master would.
module tb_dmem_port_arbiter;

  localparam int LAT = 2;
`ifdef DMEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic        m0_ack, m1_ack, mem_read, mem_write, busy, owner;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
    .clk_i(clk), .rst_i(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_ack_o(m0_ack), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_ack_o(m1_ack), .m1_rdata_o(m1_rdata),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_read_o(mem_read),
    .mem_write_o(mem_write), .mem_rdata_i(mem_rdata), .busy_o(busy), .owner_o(owner)
  );

  // Latency probes: port 1 idle, memory returns a constant.
  logic        l_req [2] = '{1'b0, 1'b0};
  logic        l_ack [2], l_ack1 [2], l_rd [2], l_wr [2], l_busy [2], l_own [2];
  logic [31:0] l_rdata [2], l_rdata1 [2], l_maddr [2], l_mwdata [2];

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_lat1 (
    .clk_i(clk), .rst_i(rst_n),
    .m0_req_i(l_req[0]), .m0_we_i(1'b0), .m0_addr_i(32'h8), .m0_wdata_i(32'h0),
    .m0_ack_o(l_ack[0]), .m0_rdata_o(l_rdata[0]),
    .m1_req_i(1'b0), .m1_we_i(1'b0), .m1_addr_i(32'h0), .m1_wdata_i(32'h0),
    .m1_ack_o(l_ack1[0]), .m1_rdata_o(l_rdata1[0]),
    .mem_addr_o(l_maddr[0]), .mem_wdata_o(l_mwdata[0]), .mem_read_o(l_rd[0]),
    .mem_write_o(l_wr[0]), .mem_rdata_i(32'hC0DE0001), .busy_o(l_busy[0]), .owner_o(l_own[0])
  );

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4)) u_lat4 (
    .clk_i(clk), .rst_i(rst_n),
    .m0_req_i(l_req[1]), .m0_we_i(1'b0), .m0_addr_i(32'h8), .m0_wdata_i(32'h0),
    .m0_ack_o(l_ack[1]), .m0_rdata_o(l_rdata[1]),
    .m1_req_i(1'b0), .m1_we_i(1'b0), .m1_addr_i(32'h0), .m1_wdata_i(32'h0),
    .m1_ack_o(l_ack1[1]), .m1_rdata_o(l_rdata1[1]),
    .mem_addr_o(l_maddr[1]), .mem_wdata_o(l_mwdata[1]), .mem_read_o(l_rd[1]),
    .mem_write_o(l_wr[1]), .mem_rdata_i(32'hC0DE0004), .busy_o(l_busy[1]), .owner_o(l_own[1])
  );

  // Power-on memory contents: a few named words, the rest a recognisable pattern.
  function automatic logic [31:0] init_word(input int idx);
    case (idx)
      4:       return 32'hDEADBEEF;   // byte address 0x10
      12:      return 32'h0BADF00D;   // byte address 0x30
      default: return 32'h1000_0000 + idx;
    endcase
  endfunction

  // Simulated Data_Memory: combinational read, write on the clock edge.
  logic [31:0] mem [64];
  logic [63:0] mem_vld = '0;
  assign mem_rdata = mem_vld[mem_addr[7:2]] ? mem[mem_addr[7:2]] : init_word(int'(mem_addr[7:2]));
  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr[7:2]]     <= mem_wdata;
      mem_vld[mem_addr[7:2]] <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Reference model ----------------
  // A granted access occupies a fixed timeline of phases 1..LAT (strobes), then LAT+1 (ack).
  int          m_phase;
  logic        m_owner, m_ptr, m_we;
  logic [31:0] m_addr, m_wdata, m_word, m_rd0, m_rd1;
  logic [31:0] exp_wr [64];
  logic [63:0] exp_vld = '0;

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return exp_vld[a[7:2]] ? exp_wr[a[7:2]] : init_word(int'(a[7:2]));
  endfunction

  logic        pick;
  always_comb begin
    pick = m1_req;
    if (m0_req && m1_req) pick = FIXED ? 1'b0 : ~m_ptr;
  end
  wire        s_we    = pick ? m1_we    : m0_we;
  wire [31:0] s_addr  = pick ? m1_addr  : m0_addr;
  wire [31:0] s_wdata = pick ? m1_wdata : m0_wdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_owner <= 1'b0; m_ptr <= 1'b1; m_we <= 1'b0;
      m_rd0   <= '0; m_rd1 <= '0;
    end else if (m_phase == 0) begin
      if (m0_req || m1_req) begin
        m_phase <= 1;
        m_owner <= pick;
        m_ptr   <= pick;
        m_we    <= s_we;
        m_addr  <= s_addr;
        m_wdata <= s_wdata;
        m_word  <= exp_word(s_addr);
        if (s_we) begin
          exp_wr[s_addr[7:2]]  <= s_wdata;
          exp_vld[s_addr[7:2]] <= 1'b1;
        end
      end
    end else if (m_phase <= LAT) begin
      m_phase <= m_phase + 1;
      if (m_phase == LAT && !m_we) begin
        if (m_owner) m_rd1 <= m_word;
        else         m_rd0 <= m_word;
      end
    end else begin
      m_phase <= 0;
    end
  end

  wire in_acc  = (m_phase >= 1) && (m_phase <= LAT);
  wire in_resp = (m_phase == LAT + 1);

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",      32'(busy),      32'(in_acc || in_resp));
      check("mem_read",  32'(mem_read),  32'(in_acc && !m_we));
      check("mem_write", 32'(mem_write), 32'(in_acc && m_we && m_phase == 1));
      check("m0_ack",    32'(m0_ack),    32'(in_resp && !m_owner));
      check("m1_ack",    32'(m1_ack),    32'(in_resp && m_owner));
      check("m0_rdata",  m0_rdata,       m_rd0);
      check("m1_rdata",  m1_rdata,       m_rd1);
      check("owner",     32'(owner),     32'(m_owner));
      if (in_acc) check("mem_addr", mem_addr, m_addr);
      if (in_acc && m_we) check("mem_wdata", mem_wdata, m_wdata);
      if (!rst_n) begin
        check("rst_mem_addr",  mem_addr,  32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
      end
    end
  end

  // ---------------- Directed stimulus ----------------
  task automatic set_port(input bit port, input bit req, input bit we,
                          input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; end
    else      begin m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; end
  endtask

  // One access on one port; reports ack cycle (1 = first cycle after the sampling edge) and strobe counts.
  task automatic do_access(input bit port, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, output int ack_cyc,
                           output int rd_cyc, output int wr_cyc, output int oth_ack);
    @(posedge clk); #2;
    set_port(port, 1'b1, we, addr, wdata);
    @(posedge clk);
    ack_cyc = -1; rd_cyc = 0; wr_cyc = 0; oth_ack = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (mem_read)  rd_cyc++;
      if (mem_write) wr_cyc++;
      if (port ? m0_ack : m1_ack) oth_ack++;
      if (port ? m1_ack : m0_ack) begin ack_cyc = n; break; end
    end
    set_port(port, 1'b0, we, addr, wdata);
    if (ack_cyc < 0) check("ack_timeout", 32'h0, 32'h1);
  endtask

  task automatic lat_probe(input int idx, input int lat);
    int n_ack;
    n_ack = -1;
    @(posedge clk); #2;
    l_req[idx] = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (l_ack[idx]) begin n_ack = n; break; end
    end
    l_req[idx] = 1'b0;
    check($sformatf("lat%0d_ack_cycle", lat), 32'(n_ack), 32'(lat + 1));
    check($sformatf("lat%0d_rdata", lat), l_rdata[idx], 32'hC0DE0000 + 32'(lat));
  endtask

  int ack_c, rd_c, wr_c, oth_c;
  int g_port [4];
  int g_cyc  [4];
  int got;

  initial begin
    #1 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    chk_en = 1'b1;
    // Reset state.
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_m0_rdata", m0_rdata, 32'h0);
    check("rst_strobes", 32'({mem_read, mem_write}), 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // 1: m0 read of a preloaded word.
    do_access(1'b0, 1'b0, 32'h10, 32'h0, ack_c, rd_c, wr_c, oth_c);
    check("t1_ack_cycle", 32'(ack_c), 32'd3);
    check("t1_read_cycles", 32'(rd_c), 32'd2);
    check("t1_m1_ack", 32'(oth_c), 32'd0);
    check("t1_rdata", m0_rdata, 32'hDEADBEEF);

    // 2: m1 write then m0 and m1 read it back.
    do_access(1'b1, 1'b1, 32'h20, 32'h12345678, ack_c, rd_c, wr_c, oth_c);
    check("t2_write_cycles", 32'(wr_c), 32'd1);
    check("t2_wr_ack_cycle", 32'(ack_c), 32'd3);
    check("t2_m1_rdata_kept", m1_rdata, 32'h0);
    do_access(1'b0, 1'b0, 32'h20, 32'h0, ack_c, rd_c, wr_c, oth_c);
    check("t2_m0_rdata", m0_rdata, 32'h12345678);
    do_access(1'b1, 1'b0, 32'h20, 32'h0, ack_c, rd_c, wr_c, oth_c);
    check("t2_m1_rdata", m1_rdata, 32'h12345678);

    // 3: both ports requesting continuously; last grant was port 1.
    @(posedge clk); #2;
    set_port(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    set_port(1'b1, 1'b1, 1'b0, 32'h24, 32'h0);
    @(posedge clk);
    got = 0;
    for (int n = 1; n <= 40 && got < 4; n++) begin
      @(negedge clk);
      if (m0_ack && got < 4) begin g_port[got] = 0; g_cyc[got] = n; got++; end
      if (m1_ack && got < 4) begin g_port[got] = 1; g_cyc[got] = n; got++; end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    check("t3_grant_count", 32'(got), 32'd4);
    check("t3_first_ack", 32'(g_cyc[0]), 32'd3);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t3_grant%0d", k), 32'(g_port[k]), FIXED ? 32'd0 : 32'(k % 2));
      if (k > 0) check($sformatf("t3_spacing%0d", k), 32'(g_cyc[k] - g_cyc[k-1]), 32'd4);
    end

    // 4: reset in the second access cycle; held request completes after release.
    @(posedge clk); #2;
    set_port(1'b0, 1'b1, 1'b0, 32'h30, 32'h0);
    @(posedge clk);
    @(posedge clk); #3;
    check("t4_read_before_rst", 32'(mem_read), 32'h1);
    rst_n = 1'b0;
    #1;
    check("t4_rst_read", 32'(mem_read), 32'h0);
    check("t4_rst_busy", 32'(busy), 32'h0);
    check("t4_rst_ack", 32'(m0_ack), 32'h0);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk);
    ack_c = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (m0_ack) begin ack_c = n; break; end
    end
    m0_req = 1'b0;
    check("t4_ack_cycle", 32'(ack_c), 32'd3);
    check("t4_rdata", m0_rdata, 32'h0BADF00D);

    // Request dropped and fields moved right after grant: access still completes on the latched address.
    @(posedge clk); #2;
    set_port(1'b1, 1'b1, 1'b0, 32'h14, 32'h0);
    @(posedge clk); #2;
    set_port(1'b1, 1'b0, 1'b1, 32'h3C, 32'hFFFF0000);
    ack_c = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (m1_ack) begin ack_c = n; break; end
    end
    check("drop_ack_cycle", 32'(ack_c), 32'd3);
    check("drop_rdata", m1_rdata, 32'h1000_0005);

    // 6: a write by m1 never disturbs m0's read register.
    do_access(1'b1, 1'b1, 32'h10, 32'h000000A5, ack_c, rd_c, wr_c, oth_c);
    do_access(1'b0, 1'b0, 32'h10, 32'h0, ack_c, rd_c, wr_c, oth_c);
    check("t6_rdata", m0_rdata, 32'h000000A5);
    do_access(1'b1, 1'b1, 32'h40, 32'h00000055, ack_c, rd_c, wr_c, oth_c);
    check("t6_rdata_kept", m0_rdata, 32'h000000A5);
    check("t6_wr_ack_cycle", 32'(ack_c), 32'd3);

    // 5: latency with MEM_LAT = 1 and 4.
    lat_probe(0, 1);
    lat_probe(1, 4);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
